// File: rtl/uart_rx_ctrl.sv
// Purpose : UART receive sequencer; start-bit qualification, bit-centre sampling, word delivery with error flags.
// Latency : start_det CLKS_PER_BIT/2 and rx_valid CLKS_PER_BIT/2 + (DATA_BITS+1+P)*CLKS_PER_BIT + 1 cycles after rx_s is first seen low, plus 2 sync cycles from rx_in.
// Backpr. : none; rx_valid is a one-cycle strobe and the consumer must take rx_data/frame_err/parity_err that cycle.
//
// Ports:
//   clk, rst         - system clock, synchronous active-high reset
//   rx_in            - asynchronous serial line, idles high
//   start_det        - pulse when the start bit is confirmed at its mid-point
//   busy             - high from falling-edge detect until the frame is finished
//   rx_data          - last received word, held until the next rx_valid
//   rx_valid         - pulse when rx_data updates
//   frame_err        - with rx_valid: stop bit sampled low
//   parity_err       - with rx_valid: parity mismatch (0 when parity is compiled out)
//
// Build option: define UART_RX_PARITY_CHECK_EN to add a parity bit after the data bits.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic                 start_det,
  output logic                 busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_CHECK_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  stop_q, stop_d;
  // Set for the single cycle between the stop sample and word delivery.
  logic                  done_q, done_d;
  logic                  start_det_q, start_det_d;
  logic                  busy_q, busy_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  parity_err_q, parity_err_d;
  logic                  rx_s;

`ifdef UART_RX_PARITY_CHECK_EN
  logic                  par_q, par_d;
`else
  // PARITY_ODD has no meaning without the parity stage.
  logic                  unused_parity_cfg;
  assign unused_parity_cfg = PARITY_ODD;
`endif

  assign rx_s = sync2_q;

  always_comb begin
    sync1_d      = rx_in;
    sync2_d      = sync1_q;
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    shift_d      = shift_q;
    stop_d       = stop_q;
    done_d       = 1'b0;
    start_det_d  = 1'b0;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
    par_d        = par_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_s) begin
            // Line went back high before mid-bit: treat as a glitch.
            state_d = IDLE;
          end else begin
            start_det_d = 1'b1;
            idx_d       = '0;
            state_d     = DATA;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_CHECK_EN
      PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (done_q) begin
          cnt_d       = '0;
          rx_data_d   = shift_q;
          rx_valid_d  = 1'b1;
          frame_err_d = !stop_q;
`ifdef UART_RX_PARITY_CHECK_EN
          parity_err_d = ((^shift_q) ^ par_q) != PARITY_ODD;
`endif
          // A low stop bit may be a break; wait for the line to idle before re-arming.
          state_d = stop_q ? IDLE : WAIT_HIGH;
        end else if (cnt_q == CNT_FULL) begin
          cnt_d  = '0;
          stop_d = rx_s;
          done_d = 1'b1;
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // busy covers the delivery cycle so the consumer sees busy fall after rx_valid.
    busy_d = (state_d != IDLE) || rx_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      stop_q       <= 1'b0;
      done_q       <= 1'b0;
      start_det_q  <= 1'b0;
      busy_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      stop_q       <= stop_d;
      done_q       <= done_d;
      start_det_q  <= start_det_d;
      busy_q       <= busy_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_CHECK_EN
      par_q        <= par_d;
`endif
    end
  end

  assign start_det  = start_det_q;
  assign busy       = busy_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Purpose : directed self-checking bench for uart_rx_ctrl with default parameters.
// Latency : frames are driven from a cycle counter; expected strobe cycles are hand-computed.
// Backpr. : none; outputs are recorded by a negedge monitor and checked per scenario.
module tb_uart_rx_ctrl;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_CHECK_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  // rx_in driven low just after edge n: sync (2) + IDLE edge (1) + half bit (8).
  localparam int START_LAT = 11;
  // 3 + 8 + 9*16 + 1 = 156 without parity, 172 with.
  localparam int LAT   = 12 + (9 + P) * CPB;
  localparam int FRAME = (10 + P) * CPB;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic       start_det;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;

  uart_rx_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .start_det  (start_det),
    .busy       (busy),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int         sq[$];
  int         vq_cyc[$];
  logic [7:0] vq_dat[$];
  logic       vq_ferr[$];
  logic       vq_perr[$];
  int         rise_q[$];
  int         fall_q[$];
  int         busy_cnt    = 0;
  int         err_outside = 0;
  logic       busy_prev   = 1'b0;

  always @(negedge clk) begin
    if (start_det === 1'b1) sq.push_back(cyc);
    if (rx_valid === 1'b1) begin
      vq_cyc.push_back(cyc);
      vq_dat.push_back(rx_data);
      vq_ferr.push_back(frame_err);
      vq_perr.push_back(parity_err);
    end else if (frame_err === 1'b1 || parity_err === 1'b1) begin
      err_outside++;
    end
    if (busy === 1'b1) busy_cnt++;
    if (busy === 1'b1 && !busy_prev) rise_q.push_back(cyc);
    if (busy === 1'b0 && busy_prev) fall_q.push_back(cyc);
    busy_prev = (busy === 1'b1);
  end

  task automatic clear_mon();
    sq.delete(); vq_cyc.delete(); vq_dat.delete(); vq_ferr.delete(); vq_perr.delete();
    rise_q.delete(); fall_q.delete();
    busy_cnt = 0; err_outside = 0;
  endtask

  task automatic align(output int n);
    @(posedge clk); #1;
    n = cyc;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_CHECK_EN
    send_bit(par);
`else
    if (par === 1'bx) rx_in = 1'b0;
`endif
    send_bit(stop);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      rx_in = ~rx_in;
    end
    @(negedge clk);
    n_cmp++;
    if ({start_det, busy, rx_valid, frame_err, parity_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000", {start_det, busy, rx_valid, frame_err, parity_err});
    end
    n_cmp++;
    if (rx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 00", rx_data);
    end
    rx_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    repeat (500) @(posedge clk);
    #1;
    n_cmp++;
    if (sq.size() + vq_cyc.size() + busy_cnt !== 0) begin
      n_bad++;
      $display("FAIL idle_quiet: got start=%0d valid=%0d busy_cycles=%0d want 0", sq.size(), vq_cyc.size(), busy_cnt);
    end
  endtask

  task automatic test_frame_a5();
    int n;
    clear_mon();
    align(n);
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (sq.size() != 1 || sq[0] !== n + START_LAT) begin
      n_bad++;
      $display("FAIL a5_start_det: got count=%0d cyc=%0d want 1 at %0d", sq.size(), (sq.size() > 0) ? sq[0] - n : -1, START_LAT);
    end
    n_cmp++;
    if (vq_cyc.size() != 1 || vq_cyc[0] !== n + LAT) begin
      n_bad++;
      $display("FAIL a5_valid_time: got count=%0d cyc=%0d want 1 at %0d", vq_cyc.size(), (vq_cyc.size() > 0) ? vq_cyc[0] - n : -1, LAT);
    end
    n_cmp++;
    if (vq_dat.size() != 1 || vq_dat[0] !== 8'hA5 || vq_ferr[0] !== 1'b0 || vq_perr[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL a5_word: got %h ferr=%b perr=%b want a5 0 0", (vq_dat.size() > 0) ? vq_dat[0] : 8'hxx, (vq_ferr.size() > 0) ? vq_ferr[0] : 1'bx, (vq_perr.size() > 0) ? vq_perr[0] : 1'bx);
    end
    n_cmp++;
    if (rise_q.size() != 1 || rise_q[0] !== n + 3 || fall_q.size() != 1 || fall_q[0] !== n + LAT + 1) begin
      n_bad++;
      $display("FAIL a5_busy: got rise=%0d fall=%0d want %0d %0d", (rise_q.size() > 0) ? rise_q[0] - n : -1, (fall_q.size() > 0) ? fall_q[0] - n : -1, 3, LAT + 1);
    end
  endtask

  task automatic test_glitch();
    int n;
    clear_mon();
    align(n);
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (sq.size() + vq_cyc.size() !== 0) begin
      n_bad++;
      $display("FAIL glitch_quiet: got start=%0d valid=%0d want 0 0", sq.size(), vq_cyc.size());
    end
    n_cmp++;
    if (busy_cnt < 1 || busy_cnt > 9 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_busy: got busy_cycles=%0d busy_now=%b want 1..9 and 0", busy_cnt, busy);
    end
  endtask

  task automatic test_break();
    int n;
    int r;
    clear_mon();
    align(n);
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL break_wait_busy: got %b want 1", busy);
    end
    @(posedge clk); #1;
    r = cyc;
    rx_in = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    n_cmp++;
    if (vq_cyc.size() != 1 || vq_cyc[0] !== n + LAT || vq_dat[0] !== 8'h3C || vq_ferr[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL break_word: got count=%0d data=%h ferr=%b want 1 3c 1", vq_cyc.size(), (vq_dat.size() > 0) ? vq_dat[0] : 8'hxx, (vq_ferr.size() > 0) ? vq_ferr[0] : 1'bx);
    end
    n_cmp++;
    if (fall_q.size() != 1 || fall_q[0] !== r + 3) begin
      n_bad++;
      $display("FAIL break_busy_release: got count=%0d at=%0d want 1 at %0d", fall_q.size(), (fall_q.size() > 0) ? fall_q[0] - r : -1, 3);
    end
    n_cmp++;
    if (sq.size() != 1 || err_outside != 0) begin
      n_bad++;
      $display("FAIL break_no_refire: got start=%0d stray_err=%0d want 1 0", sq.size(), err_outside);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_mon();
    align(n);
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    rx_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (vq_cyc.size() != 2 || vq_cyc[0] !== n + LAT || vq_cyc[1] !== n + LAT + FRAME) begin
      n_bad++;
      $display("FAIL b2b_timing: got count=%0d gap=%0d want 2 gap %0d", vq_cyc.size(), (vq_cyc.size() > 1) ? vq_cyc[1] - vq_cyc[0] : -1, FRAME);
    end
    n_cmp++;
    if (vq_dat.size() != 2 || vq_dat[0] !== 8'h00 || vq_dat[1] !== 8'hFF || vq_ferr[0] !== 1'b0 || vq_ferr[1] !== 1'b0 || vq_perr[0] !== 1'b0 || vq_perr[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_words: got %h %h want 00 ff without errors", (vq_dat.size() > 0) ? vq_dat[0] : 8'hxx, (vq_dat.size() > 1) ? vq_dat[1] : 8'hxx);
    end
    n_cmp++;
    if (rx_data !== 8'hFF) begin
      n_bad++;
      $display("FAIL b2b_hold: got %h want ff", rx_data);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    clear_mon();
    align(n);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    rx_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_busy: got %b want 0", busy);
    end
    repeat (200) @(posedge clk);
    #1;
    n_cmp++;
    if (vq_cyc.size() != 0 || sq.size() != 1) begin
      n_bad++;
      $display("FAIL midrst_abort: got valid=%0d start=%0d want 0 1", vq_cyc.size(), sq.size());
    end
  endtask

`ifdef UART_RX_PARITY_CHECK_EN
  task automatic test_parity();
    int n;
    clear_mon();
    align(n);
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (vq_cyc.size() != 2 || vq_dat[0] !== 8'h07 || vq_perr[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL parity_good: got count=%0d data=%h perr=%b want 2 07 0", vq_cyc.size(), (vq_dat.size() > 0) ? vq_dat[0] : 8'hxx, (vq_perr.size() > 0) ? vq_perr[0] : 1'bx);
    end
    n_cmp++;
    if (vq_cyc.size() != 2 || vq_dat[1] !== 8'h07 || vq_perr[1] !== 1'b1 || vq_ferr[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL parity_bad: got count=%0d data=%h perr=%b want 2 07 1", vq_cyc.size(), (vq_dat.size() > 1) ? vq_dat[1] : 8'hxx, (vq_perr.size() > 1) ? vq_perr[1] : 1'bx);
    end
  endtask
`endif

  initial begin
    rst   = 1'b1;
    rx_in = 1'b1;
    test_reset();
    test_frame_a5();
    test_glitch();
    test_break();
    test_back_to_back();
    test_mid_reset();
`ifdef UART_RX_PARITY_CHECK_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
